// File: rtl/rf_writeback_unit.sv
// rf_writeback_unit: arbitrates ALU/LSU results onto the RF write port and tracks pending destinations.
module rf_writeback_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_stall_i,
   input  logic        id_issue_i,
   input  logic [4:0]  id_dst_i,
   input  logic [4:0]  id_src1_i,
   input  logic [4:0]  id_src2_i,
   output logic        id_hazard_o,
   input  logic        alu_valid_i,
   input  logic [4:0]  alu_dst_i,
   input  logic [31:0] alu_data_i,
   output logic        alu_ready_o,
   input  logic        lsu_valid_i,
   input  logic [4:0]  lsu_dst_i,
   input  logic [31:0] lsu_data_i,
   output logic        lsu_ready_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_dst_o,
   output logic [31:0] rf_dst_d_o,
   output logic [31:0] pending_o,
   output logic        err_o
);
   logic [31:0] r_pend;
   logic [1:0]  r_cnt;
   logic        r_we;
   logic [4:0]  r_dst;
   logic [31:0] r_data;
   logic        r_err;
   logic        w_alu_gnt;
   logic        w_lsu_gnt;
   logic        w_acc;
   logic        w_wr;
   logic [4:0]  w_dst;
   logic [31:0] w_data;
   logic [31:0] w_pend_nxt;
   logic        w_hazard;
   assign w_hazard = r_pend[id_src1_i] | r_pend[id_src2_i] | r_pend[id_dst_i];
   // LSU wins contention unless the ALU has already lost twice in a row
   always_comb begin
      w_alu_gnt  = alu_valid_i & (!lsu_valid_i | r_cnt == 2'd2);
      w_lsu_gnt  = lsu_valid_i & !w_alu_gnt;
      w_acc      = !wb_stall_i & (w_alu_gnt | w_lsu_gnt);
      w_dst      = w_alu_gnt ? alu_dst_i : lsu_dst_i;
      w_data     = w_alu_gnt ? alu_data_i : lsu_data_i;
      w_wr       = w_acc & (w_dst != 5'd0);
      w_pend_nxt = r_pend;
      if (!wb_stall_i && r_we) w_pend_nxt[r_dst] = 1'b0;
      if (!wb_stall_i && id_issue_i && !w_hazard) w_pend_nxt[id_dst_i] = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= '0;
         r_cnt  <= '0;
         r_we   <= 1'b0;
         r_dst  <= '0;
         r_data <= '0;
         r_err  <= 1'b0;
      end else begin
         r_pend <= w_pend_nxt;
         if (w_wr && !r_pend[w_dst]) r_err <= 1'b1;
         r_cnt <= (!alu_valid_i || (w_alu_gnt && !wb_stall_i)) ? 2'd0 :
                  (!wb_stall_i && lsu_valid_i) ? r_cnt + 2'd1 : r_cnt;
         if (!wb_stall_i) begin
            r_we <= w_wr;
            if (w_wr) begin
               r_dst  <= w_dst;
               r_data <= w_data;
            end
         end
      end
   end
   assign id_hazard_o = w_hazard;
   assign alu_ready_o = !wb_stall_i & w_alu_gnt;
   assign lsu_ready_o = !wb_stall_i & w_lsu_gnt;
   assign rf_we_o     = r_we;
   assign rf_dst_o    = r_dst;
   assign rf_dst_d_o  = r_data;
   assign pending_o   = r_pend;
   assign err_o       = r_err;
endmodule

// File: tb/tb_rf_writeback_unit.sv
// tb_rf_writeback_unit: directed scenarios plus a randomized run against a behavioural scoreboard model.
module tb_rf_writeback_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        wb_stall_i;
   logic        id_issue_i;
   logic [4:0]  id_dst_i, id_src1_i, id_src2_i;
   logic        id_hazard_o;
   logic        alu_valid_i, lsu_valid_i;
   logic [4:0]  alu_dst_i, lsu_dst_i;
   logic [31:0] alu_data_i, lsu_data_i;
   logic        alu_ready_o, lsu_ready_o;
   logic        rf_we_o;
   logic [4:0]  rf_dst_o;
   logic [31:0] rf_dst_d_o;
   logic [31:0] pending_o;
   logic        err_o;
   int n_tests = 0;
   int n_fail = 0;

   rf_writeback_unit dut (
      .clk(clk), .rst(rst), .wb_stall_i(wb_stall_i),
      .id_issue_i(id_issue_i), .id_dst_i(id_dst_i), .id_src1_i(id_src1_i), .id_src2_i(id_src2_i),
      .id_hazard_o(id_hazard_o),
      .alu_valid_i(alu_valid_i), .alu_dst_i(alu_dst_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
      .lsu_valid_i(lsu_valid_i), .lsu_dst_i(lsu_dst_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
      .rf_we_o(rf_we_o), .rf_dst_o(rf_dst_o), .rf_dst_d_o(rf_dst_d_o),
      .pending_o(pending_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; wb_stall_i = 1'b0; id_issue_i = 1'b0;
      id_dst_i = '0; id_src1_i = '0; id_src2_i = '0;
      alu_valid_i = 1'b0; alu_dst_i = '0; alu_data_i = '0;
      lsu_valid_i = 1'b0; lsu_dst_i = '0; lsu_data_i = '0;
   endtask

   task automatic issue(input logic [4:0] d);
      id_issue_i = 1'b1; id_dst_i = d;
      tick();
      id_issue_i = 1'b0; id_dst_i = '0;
   endtask

   task automatic alu_write(input logic [4:0] d, input logic [31:0] v);
      alu_valid_i = 1'b1; alu_dst_i = d; alu_data_i = v;
      tick();
      alu_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      n_tests++;
      if ({rf_we_o, rf_dst_o, rf_dst_d_o, pending_o, err_o} !== 71'd0) begin
         n_fail++;
         $display("FAIL reset: we=%b dst=%0d d=%h pend=%h err=%b, required all zero", rf_we_o, rf_dst_o, rf_dst_d_o, pending_o, err_o);
      end
   endtask

   task automatic test_basic();
      issue(5'd5);
      id_src1_i = 5'd5;
      #1;
      n_tests++;
      if (pending_o[5] !== 1'b1 || id_hazard_o !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_issue: pend5=%b hazard=%b, required 1 1", pending_o[5], id_hazard_o);
      end
      alu_valid_i = 1'b1; alu_dst_i = 5'd5; alu_data_i = 32'hDEADBEEF;
      #1;
      n_tests++;
      if (alu_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_ready: alu_ready=%b, required 1", alu_ready_o);
      end
      tick();
      alu_valid_i = 1'b0;
      #1;
      n_tests++;
      if (rf_we_o !== 1'b1 || rf_dst_o !== 5'd5 || rf_dst_d_o !== 32'hDEADBEEF || pending_o[5] !== 1'b1 || id_hazard_o !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_write: we=%b dst=%0d d=%h pend5=%b hz=%b, required 1 5 deadbeef 1 1", rf_we_o, rf_dst_o, rf_dst_d_o, pending_o[5], id_hazard_o);
      end
      tick();
      n_tests++;
      if (rf_we_o !== 1'b0 || pending_o[5] !== 1'b0 || id_hazard_o !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_retire: we=%b pend5=%b hz=%b, required 0 0 0", rf_we_o, pending_o[5], id_hazard_o);
      end
      idle();
   endtask

   task automatic test_arbitration();
      logic [4:0] alu_l [2] = '{5'd10, 5'd13};
      logic [4:0] lsu_l [4] = '{5'd11, 5'd12, 5'd14, 5'd15};
      string exp_s = "LLALLA";
      string got_s = "";
      int ai = 0, li = 0;
      for (int r = 10; r <= 15; r++) issue(5'(r));
      #1;
      n_tests++;
      if (pending_o[15:10] !== 6'h3f) begin
         n_fail++;
         $display("FAIL arb_issue: pend[15:10]=%b, required 111111", pending_o[15:10]);
      end
      for (int k = 0; k < 6; k++) begin
         alu_valid_i = 1'b1; alu_dst_i = alu_l[ai]; alu_data_i = $urandom;
         lsu_valid_i = 1'b1; lsu_dst_i = lsu_l[li]; lsu_data_i = $urandom;
         #1;
         if (alu_ready_o && !lsu_ready_o) begin
            got_s = {got_s, "A"};
            if (ai < 1) ai++;
         end else if (lsu_ready_o && !alu_ready_o) begin
            got_s = {got_s, "L"};
            if (li < 3) li++;
         end else got_s = {got_s, "?"};
         tick();
      end
      idle();
      n_tests++;
      if (got_s != exp_s) begin
         n_fail++;
         $display("FAIL arb_order: got %s, required %s", got_s, exp_s);
      end
      tick(); tick();
      n_tests++;
      if (pending_o[15:10] !== 6'h00 || err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL arb_retire: pend[15:10]=%b err=%b, required 000000 0", pending_o[15:10], err_o);
      end
   endtask

   task automatic test_stall();
      logic [31:0] v = $urandom;
      issue(5'd7);
      alu_write(5'd7, v);
      wb_stall_i = 1'b1;
      alu_valid_i = 1'b1; alu_dst_i = 5'd0; lsu_valid_i = 1'b1; lsu_dst_i = 5'd0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_tests++;
         if (rf_we_o !== 1'b1 || rf_dst_o !== 5'd7 || rf_dst_d_o !== v || alu_ready_o !== 1'b0 || lsu_ready_o !== 1'b0 || pending_o[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold%0d: we=%b dst=%0d d=%h ar=%b lr=%b pend7=%b, required 1 7 %h 0 0 1", k, rf_we_o, rf_dst_o, rf_dst_d_o, alu_ready_o, lsu_ready_o, pending_o[7], v);
         end
         tick();
      end
      idle();
      tick();
      n_tests++;
      if (pending_o[7] !== 1'b0 || rf_we_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_retire: pend7=%b we=%b, required 0 0", pending_o[7], rf_we_o);
      end
   endtask

   task automatic test_waw();
      issue(5'd3);
      id_issue_i = 1'b1; id_dst_i = 5'd3;
      #1;
      n_tests++;
      if (id_hazard_o !== 1'b1) begin
         n_fail++;
         $display("FAIL waw_hazard: hazard=%b, required 1", id_hazard_o);
      end
      tick();
      id_dst_i = 5'd8; id_src1_i = 5'd3;
      #1;
      n_tests++;
      if (id_hazard_o !== 1'b1) begin
         n_fail++;
         $display("FAIL raw_hazard: hazard=%b, required 1", id_hazard_o);
      end
      tick();
      idle();
      n_tests++;
      if (pending_o[8] !== 1'b0) begin
         n_fail++;
         $display("FAIL hazard_issue_ignored: pend8=%b, required 0", pending_o[8]);
      end
      alu_write(5'd3, 32'h1);
      tick();
      n_tests++;
      if (pending_o !== 32'd0 || err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL waw_retire: pend=%h err=%b, required 0 0", pending_o, err_o);
      end
   endtask

   task automatic test_x0();
      logic [31:0] p;
      issue(5'd6);
      p = pending_o;
      lsu_valid_i = 1'b1; lsu_dst_i = 5'd0; lsu_data_i = 32'hCAFE0000;
      #1;
      n_tests++;
      if (lsu_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL x0_ready: lsu_ready=%b, required 1", lsu_ready_o);
      end
      tick();
      idle();
      n_tests++;
      if (rf_we_o !== 1'b0 || pending_o !== p || err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL x0_write: we=%b pend=%h err=%b, required 0 %h 0", rf_we_o, pending_o, err_o, p);
      end
      alu_write(5'd6, 32'h6);
      tick();
   endtask

   task automatic test_err_and_reset();
      alu_write(5'd9, 32'h99);
      n_tests++;
      if (rf_we_o !== 1'b1 || rf_dst_o !== 5'd9 || err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL err_set: we=%b dst=%0d err=%b, required 1 9 1", rf_we_o, rf_dst_o, err_o);
      end
      tick(); tick();
      n_tests++;
      if (err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: err=%b, required 1", err_o);
      end
      issue(5'd4);
      alu_write(5'd4, 32'h44);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if ({rf_we_o, rf_dst_o, rf_dst_d_o, pending_o, err_o} !== 71'd0) begin
         n_fail++;
         $display("FAIL reset_inflight: we=%b dst=%0d d=%h pend=%h err=%b, required all zero", rf_we_o, rf_dst_o, rf_dst_d_o, pending_o, err_o);
      end
   endtask

   task automatic test_random();
      logic [31:0] mp = '0, mdat = '0;
      logic [4:0]  md = '0;
      logic        mwe = 1'b0, me = 1'b0;
      int          losses = 0;
      logic        hz, aw, lw, acc;
      logic [4:0]  ad;
      logic [31:0] ad_v;
      for (int c = 0; c < 400; c++) begin
         wb_stall_i  = ($urandom_range(0, 4) == 0);
         id_issue_i  = $urandom_range(0, 1);
         id_dst_i    = 5'($urandom_range(0, 7));
         id_src1_i   = 5'($urandom_range(0, 7));
         id_src2_i   = 5'($urandom_range(0, 7));
         alu_valid_i = ($urandom_range(0, 4) < 3);
         alu_dst_i   = 5'($urandom_range(0, 7));
         alu_data_i  = $urandom;
         lsu_valid_i = ($urandom_range(0, 4) < 3);
         lsu_dst_i   = 5'($urandom_range(0, 7));
         lsu_data_i  = $urandom;
         #1;
         hz = (id_src1_i != 0 && mp[id_src1_i]) || (id_src2_i != 0 && mp[id_src2_i]) || (id_dst_i != 0 && mp[id_dst_i]);
         if (alu_valid_i && lsu_valid_i) aw = (losses == 2);
         else aw = alu_valid_i;
         lw = lsu_valid_i && !aw;
         n_tests++;
         if (id_hazard_o !== hz || alu_ready_o !== (!wb_stall_i && aw) || lsu_ready_o !== (!wb_stall_i && lw)) begin
            n_fail++;
            $display("FAIL rand_comb c%0d: hz=%b ar=%b lr=%b, required %b %b %b", c, id_hazard_o, alu_ready_o, lsu_ready_o, hz, !wb_stall_i && aw, !wb_stall_i && lw);
         end
         n_tests++;
         if (rf_we_o !== mwe || rf_dst_o !== md || rf_dst_d_o !== mdat) begin
            n_fail++;
            $display("FAIL rand_port c%0d: we=%b dst=%0d d=%h, required %b %0d %h", c, rf_we_o, rf_dst_o, rf_dst_d_o, mwe, md, mdat);
         end
         n_tests++;
         if (pending_o !== mp || err_o !== me) begin
            n_fail++;
            $display("FAIL rand_sb c%0d: pend=%h err=%b, required %h %b", c, pending_o, err_o, mp, me);
         end
         ad   = aw ? alu_dst_i : lsu_dst_i;
         ad_v = aw ? alu_data_i : lsu_data_i;
         acc  = aw || lw;
         if (!alu_valid_i) losses = 0;
         else if (!wb_stall_i && aw) losses = 0;
         else if (!wb_stall_i && lsu_valid_i) losses++;
         if (!wb_stall_i) begin
            if (acc && ad != 0 && !mp[ad]) me = 1'b1;
            if (mwe) mp[md] = 1'b0;
            if (id_issue_i && !hz && id_dst_i != 0) mp[id_dst_i] = 1'b1;
            mwe = acc && ad != 0;
            if (mwe) begin
               md = ad;
               mdat = ad_v;
            end
         end
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_basic();
      test_arbitration();
      test_stall();
      test_waw();
      test_x0();
      test_err_and_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
